// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the two-port memory arbiter.
package mem_port_arbiter_pkg;

  // Default number of 32-bit words in the shared memory.
  localparam int unsigned MEM_DEPTH_DEFAULT = 2048;

  // Port identifiers, also the encoding of the last-grant register.
  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_LOAD = 1'b1;

  // Contents of one per-port response register.
  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

endpackage

// File: rtl/mem_port_arbiter_resp_reg.sv
// Per-port response holding register: loads on grant, holds until consumed.
module mem_resp_reg
  import mem_port_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_rdata,
  input  logic        load_err,
  input  logic        resp_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  resp_t resp_d, resp_q;

  // A new grant wins over consumption, so back-to-back accepts reload directly.
  always_comb begin
    resp_d = resp_q;
    if (load) begin
      resp_d.valid = 1'b1;
      resp_d.rdata = load_rdata;
      resp_d.err   = load_err;
    end else if (resp_ready) begin
      resp_d = '0;
    end
  end

  // Response state; pending responses are dropped on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q <= '0;
    end else begin
      resp_q <= resp_d;
    end
  end

  assign resp_valid = resp_q.valid;
  assign resp_rdata = resp_q.rdata;
  assign resp_err   = resp_q.err;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing a single-port memory between the CPU LSU (port 0)
// and the program loader/debug master (port 1), with registered responses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEFAULT,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_write,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [31:0]       p0_req_wdata,
  output logic              p0_resp_valid,
  input  logic              p0_resp_ready,
  output logic [31:0]       p0_resp_rdata,
  output logic              p0_resp_err,

  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_write,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [31:0]       p1_req_wdata,
  output logic              p1_resp_valid,
  input  logic              p1_resp_ready,
  output logic [31:0]       p1_resp_rdata,
  output logic              p1_resp_err,

  output logic [31:0]       mem_read_address,
  input  logic [31:0]       mem_read_data,
  output logic [31:0]       mem_write_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_write_enable
);

  // Full-width limit so high address bits are never silently dropped.
  localparam logic [ADDR_W-1:0] DepthLimit = ADDR_W'(MEM_DEPTH);

  logic              last_grant_d, last_grant_q;
  logic              elig0, elig1;
  logic              grant0, grant1;
  logic [ADDR_W-1:0] gnt_addr;
  logic [31:0]       gnt_wdata;
  logic              gnt_write;
  logic              in_range;
  logic [31:0]       load_rdata;
  logic              load_err;

  // Arbitration, request mux and memory drive.
  always_comb begin
    // A port may issue if its response slot is free or is being drained now.
    elig0  = p0_req_valid && !(p0_resp_valid && !p0_resp_ready);
    elig1  = p1_req_valid && !(p1_resp_valid && !p1_resp_ready);
    grant0 = elig0 && (!elig1 || (last_grant_q == PORT_LOAD));
    grant1 = elig1 && !grant0;

    gnt_addr  = '0;
    gnt_wdata = '0;
    gnt_write = 1'b0;
    if (grant0) begin
      gnt_addr  = p0_req_addr;
      gnt_wdata = p0_req_wdata;
      gnt_write = p0_req_write;
    end else if (grant1) begin
      gnt_addr  = p1_req_addr;
      gnt_wdata = p1_req_wdata;
      gnt_write = p1_req_write;
    end

    in_range   = gnt_addr < DepthLimit;
    load_rdata = (!gnt_write && in_range) ? mem_read_data : 32'h0;
    load_err   = !in_range;

    last_grant_d = last_grant_q;
    if (grant0) begin
      last_grant_d = PORT_CPU;
    end else if (grant1) begin
      last_grant_d = PORT_LOAD;
    end
  end

  // Round-robin pointer; reset value lets port 0 win the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= PORT_LOAD;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign p0_req_ready      = grant0;
  assign p1_req_ready      = grant1;
  assign mem_read_address  = 32'(gnt_addr);
  assign mem_write_address = 32'(gnt_addr);
  assign mem_write_data    = gnt_wdata;
  assign mem_write_enable  = (grant0 || grant1) && gnt_write && in_range;

  mem_resp_reg u_resp_p0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (grant0),
    .load_rdata (load_rdata),
    .load_err   (load_err),
    .resp_ready (p0_resp_ready),
    .resp_valid (p0_resp_valid),
    .resp_rdata (p0_resp_rdata),
    .resp_err   (p0_resp_err)
  );

  mem_resp_reg u_resp_p1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (grant1),
    .load_rdata (load_rdata),
    .load_err   (load_err),
    .resp_ready (p1_resp_ready),
    .resp_valid (p1_resp_valid),
    .resp_rdata (p1_resp_rdata),
    .resp_err   (p1_resp_err)
  );

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port main memory (word-addressed, combinational read, write on clock edge) between two requesters. Port 0 is the CPU load/store unit; port 1 is the program loader/debug master.
- Accepts at most one access per cycle using round-robin arbitration and drives the memory's read_address/write_address/write_data/write_enable.
- Returns a registered response per port, with backpressure and out-of-range detection.

Parameters:
- MEM_DEPTH, 2048, number of 32-bit words in the memory; valid word addresses are 0..MEM_DEPTH-1.
- ADDR_W, 32, request address width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- p0_req_valid / p1_req_valid  input  1  request present.
- p0_req_ready / p1_req_ready  output  1  request accepted this cycle.
- p0_req_write / p1_req_write  input  1  1 = write, 0 = read.
- p0_req_addr / p1_req_addr  input  ADDR_W  word address.
- p0_req_wdata / p1_req_wdata  input  32  write data.
- p0_resp_valid / p1_resp_valid  output  1  response held in the response register.
- p0_resp_ready / p1_resp_ready  input  1  requester consumes the response.
- p0_resp_rdata / p1_resp_rdata  output  32  read data; 0 for writes and errors.
- p0_resp_err / p1_resp_err  output  1  address was out of range.
- mem_read_address  output  32  to memory read_address.
- mem_read_data  input  32  from memory read_data.
- mem_write_address  output  32  to memory write_address.
- mem_write_data  output  32  to memory write_data.
- mem_write_enable  output  1  to memory write_enable.

Behaviour:
- Reset (rst_n low, asynchronous): resp_valid=0, resp_rdata=0, resp_err=0 on both ports; last_grant=1, so port 0 wins the first contention. Combinational outputs follow from the reset state: req_ready=0 unless valid, and mem_write_enable=0.
- Eligibility: port p is eligible when req_valid_p && !(resp_valid_p && !resp_ready_p). A port may issue when its pending response is being consumed in the same cycle.
- Arbitration (combinational, one grant per cycle):
  - If only one port is eligible, that port is granted.
  - If both are eligible, the port != last_grant is granted.
  - last_grant updates to the granted port on the clock edge; it holds when nothing is granted.
- req_ready_p = grant_p. It may depend on req_valid. Requesters must not make req_valid depend on req_ready, and must hold address/data/write stable while valid && !ready.
- Memory drive:
  - mem_read_address and mem_write_address = granted address, or 0 when idle.
  - mem_write_data = granted wdata.
  - mem_write_enable = grant && req_write && in_range; it is never asserted when there is no grant.
- in_range means addr < MEM_DEPTH, compared on the full ADDR_W width with no truncation.
- Response timing: a request accepted in cycle N has its response registered at the end of cycle N, so resp_valid is high from cycle N+1.
  - Read, in range: rdata = mem_read_data sampled in cycle N; err=0.
  - Write, in range: rdata=0, err=0. Memory content is updated at the same edge.
  - Out of range: write suppressed, rdata=0, err=1.
- Response hold: resp_valid, rdata and err hold until resp_ready. They clear on resp_ready unless a new grant to that port occurs in the same cycle, in which case the new response loads.
- Ordering: at most one outstanding response per port; responses are in order per port. Back-to-back accepts from one port every cycle are allowed when resp_ready is held high.
- Ordering across ports follows grant order. A write by port 1 in cycle N is visible to a port 0 read granted in cycle N+1 or later.
- Reset mid-operation: pending responses are discarded; a write granted in the cycle reset asserts may or may not land.

Decomposition:
- Shared package: MEM_DEPTH default, PORT_CPU=0 and PORT_LOAD=1 constants, and a response struct (valid, rdata, err).
- One natural sub-module: mem_resp_reg, the per-port response holding register (load/hold/clear logic), instantiated twice.
- Arbitration and memory muxing stay in the top module.

Test Plan:
- Single read: preload mem[5]=0xDEADBEEF; p0 reads addr 5 -> p0_req_ready in the same cycle, next cycle p0_resp_valid=1, rdata=0xDEADBEEF, err=0.
- Contention fairness: both ports hold valid reads for 4 cycles with resp_ready=1 -> grants alternate p0, p1, p0, p1; mem_write_enable=0 throughout.
- Write then read: p1 writes 0x12345678 to addr 100 in cycle N, p0 reads addr 100 in cycle N+1 -> p0 rdata=0x12345678; p1 response has rdata=0, err=0.
- Out of range: p0 writes addr 2048 with data 0xFFFFFFFF -> mem_write_enable stays 0, resp_err=1, rdata=0; a following read of addr 0 is unchanged.
- Backpressure: p0 issues a read with p0_resp_ready=0 -> response held stable and p0_req_ready=0 for a second p0 request. p1 is still granted. Raising resp_ready lets the second p0 request be accepted in that same cycle.
- Async reset: assert rst_n low between clock edges while p1_resp_valid=1 -> resp_valid drops immediately; after release, simultaneous requests grant p0 first.
